ecc_scalar_mult: RTL and testbench

- Scalar-multiplication sequencer; computes R = k·P by left-to-right double-and-add.
- Acts as the initiator of the top_ecc start/done handshake. It issues point-double and point-add requests to one top_ecc instance and collects rx/ry.
- Sits between the host interface and top_ecc. The arithmetic core itself is not part of this block.

---
 rtl/ecc_pkg.sv | 28 ++
 rtl/ecc_core_req.sv | 128 ++++++++++++
 rtl/ecc_scalar_mult.sv | 197 +++++++++++++++++++
 tb/tb_ecc_scalar_mult.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC scalar-multiplication sequencer and its core
// request initiator: coordinate/bus widths, operand flag positions, the affine
// point type, the point-at-infinity encoding and the FSM state types.
package ecc_pkg;

   localparam int unsigned COORD_W      = 79;
   localparam int unsigned BUS_W        = 80;
   // Bit 79 of core_px requests a doubling; bit 79 of core_qy requests negation.
   localparam int unsigned FLAG_DBL_BIT = 79;
   localparam int unsigned FLAG_NEG_BIT = 79;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } point_t;

   // O is (0,0), the same zero-operand convention the core uses.
   localparam point_t POINT_INF = '0;

   typedef enum logic [1:0] {SqIdle, SqStep, SqCore, SqFin} seq_state_e;
   typedef enum logic [1:0] {StIdle, StReq, StWait, StRelease} req_state_e;
   typedef enum logic {PhDbl, PhAdd} phase_e;

   function automatic logic is_inf(input point_t p);
      return (p == POINT_INF);
   endfunction

endpackage

// File: rtl/ecc_core_req.sv
// Core transaction initiator: runs one REQ -> WAIT -> RELEASE handshake with the
// arithmetic core per i_go, holding operands stable for the whole transaction.
// Optional watchdog (macro ECC_SCALAR_MULT_TIMEOUT_EN) aborts a transaction that
// spends TIMEOUT_CYCLES cycles in WAIT/RELEASE.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   i_go                  start a transaction (honoured in idle only)
//   i_px/i_py/i_qx/i_qy   operands latched on accepted i_go
//   o_capture             core result valid on o_res this cycle
//   o_res                 core result (bit 79 of each coordinate dropped)
//   o_finish              transaction complete (core_done has fallen)
//   o_timeout             watchdog expiry pulse (0 when feature not built)
//   core_*                handshake and operand buses to/from the core
module ecc_core_req
   import ecc_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_go,
   input  logic [BUS_W-1:0] i_px,
   input  logic [BUS_W-1:0] i_py,
   input  logic [BUS_W-1:0] i_qx,
   input  logic [BUS_W-1:0] i_qy,
   output logic             o_capture,
   output point_t           o_res,
   output logic             o_finish,
   output logic             o_timeout,
   output logic             core_start,
   output logic [BUS_W-1:0] core_px,
   output logic [BUS_W-1:0] core_py,
   output logic [BUS_W-1:0] core_qx,
   output logic [BUS_W-1:0] core_qy,
   input  logic             core_done,
   input  logic [BUS_W-1:0] core_rx,
   input  logic [BUS_W-1:0] core_ry
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   req_state_e       r_state, w_state_d;
   logic [BUS_W-1:0] r_px, r_py, r_qx, r_qy;
   logic             w_timeout;
   logic             w_unused_msb;

   assign w_unused_msb = core_rx[BUS_W-1] ^ core_ry[BUS_W-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= StIdle;
         r_px    <= '0;
         r_py    <= '0;
         r_qx    <= '0;
         r_qy    <= '0;
      end else begin
         r_state <= w_state_d;
         if (r_state == StIdle && i_go) begin
            r_px <= i_px;
            r_py <= i_py;
            r_qx <= i_qx;
            r_qy <= i_qy;
         end
      end
   end

   always_comb begin
      w_state_d = r_state;
      o_capture = 1'b0;
      o_finish  = 1'b0;
      case (r_state)
         StIdle:    if (i_go) w_state_d = StReq;
         StReq:     w_state_d = StWait;
         StWait: begin
            if (core_done) begin
               o_capture = 1'b1;
               w_state_d = StRelease;
            end
         end
         // No new request until core_done is low again.
         StRelease: begin
            if (!core_done) begin
               o_finish  = 1'b1;
               w_state_d = StIdle;
            end
         end
         default:   w_state_d = StIdle;
      endcase
      if (w_timeout) begin
         o_capture = 1'b0;
         o_finish  = 1'b0;
         w_state_d = StIdle;
      end
   end

`ifdef ECC_SCALAR_MULT_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_wd_cnt;
   logic             w_wd_run;

   assign w_wd_run  = (r_state == StWait) || (r_state == StRelease);
   assign w_timeout = w_wd_run && (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wd_cnt <= '0;
      end else if (!w_wd_run) begin
         r_wd_cnt <= '0;
      end else begin
         r_wd_cnt <= r_wd_cnt + CNT_W'(1);
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   assign o_timeout  = w_timeout;
   assign o_res      = {core_rx[COORD_W-1:0], core_ry[COORD_W-1:0]};
   assign core_start = (r_state == StReq);
   assign core_px    = r_px;
   assign core_py    = r_py;
   assign core_qx    = r_qx;
   assign core_qy    = r_qy;

endmodule

// File: rtl/ecc_scalar_mult.sv
// Scalar-multiplication sequencer: R = k*P by left-to-right double-and-add,
// issuing point-double / point-add requests to an external core through
// ecc_core_req. Doubling or adding against O is short-cut locally in one cycle.
// Optional watchdog: macro ECC_SCALAR_MULT_TIMEOUT_EN (err sticky, rx=ry=0 on expiry).
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   start, k, px, py  request, scalar and base point (bit 79 of px/py ignored)
//   busy, done        busy from accepted start until done; done is a 1-cycle pulse
//   rx, ry            result (bit 79 always 0), held until the next accepted start
//   err               sticky watchdog error, cleared on accepted start
//   core_*            request/response buses to the arithmetic core
module ecc_scalar_mult
   import ecc_pkg::*;
#(
   parameter int unsigned K_W            = 79,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [K_W-1:0]   k,
   input  logic [BUS_W-1:0] px,
   input  logic [BUS_W-1:0] py,
   output logic             busy,
   output logic             done,
   output logic [BUS_W-1:0] rx,
   output logic [BUS_W-1:0] ry,
   output logic             err,
   output logic             core_start,
   output logic [BUS_W-1:0] core_px,
   output logic [BUS_W-1:0] core_py,
   output logic [BUS_W-1:0] core_qx,
   output logic [BUS_W-1:0] core_qy,
   input  logic             core_done,
   input  logic [BUS_W-1:0] core_rx,
   input  logic [BUS_W-1:0] core_ry
);

   localparam int unsigned IDX_W = (K_W > 1) ? $clog2(K_W) : 1;

   seq_state_e       r_state, w_state_d;
   phase_e           r_phase, w_phase_d;
   logic [K_W-1:0]   r_k;
   logic [IDX_W-1:0] r_idx, w_idx_d;
   point_t           r_p, r_r, w_r_d;
   logic             r_done;
   logic [BUS_W-1:0] r_rx, r_ry;

   logic             w_go, w_advance, w_bit, w_dbl;
   logic [BUS_W-1:0] w_op_px, w_op_py, w_op_qx, w_op_qy;
   logic             w_capture, w_finish, w_timeout;
   point_t           w_res;
   logic             w_unused_msb;

   assign w_unused_msb = px[BUS_W-1] ^ py[BUS_W-1];
   assign w_bit        = r_k[r_idx];

   // An add with R==P would be degenerate for the core, so it becomes a double.
   always_comb begin
      w_dbl                 = (r_phase == PhDbl) || (r_r == r_p);
      w_op_px               = {1'b0, r_r.x};
      w_op_px[FLAG_DBL_BIT] = w_dbl;
      w_op_py               = {1'b0, r_r.y};
      w_op_qx               = w_dbl ? '0 : {1'b0, r_p.x};
      w_op_qy               = w_dbl ? '0 : {1'b0, r_p.y};
      w_op_qy[FLAG_NEG_BIT] = 1'b0;
   end

   always_comb begin
      w_state_d = r_state;
      w_phase_d = r_phase;
      w_idx_d   = r_idx;
      w_r_d     = r_r;
      w_go      = 1'b0;
      w_advance = 1'b0;
      case (r_state)
         SqIdle: begin
            if (start) begin
               w_state_d = SqStep;
               w_phase_d = PhDbl;
               w_idx_d   = IDX_W'(K_W - 1);
               w_r_d     = POINT_INF;
            end
         end
         SqStep: begin
            if (is_inf(r_r)) begin
               // 2*O = O, O + P = P: no core work needed.
               if (r_phase == PhAdd) w_r_d = r_p;
               w_advance = 1'b1;
            end else begin
               w_go      = 1'b1;
               w_state_d = SqCore;
            end
         end
         SqCore: begin
            if (w_capture) w_r_d = w_res;
            if (w_timeout) begin
               w_r_d     = POINT_INF;
               w_state_d = SqFin;
            end else if (w_finish) begin
               w_advance = 1'b1;
            end
         end
         SqFin:   w_state_d = SqIdle;
         default: w_state_d = SqIdle;
      endcase

      if (w_advance) begin
         if (r_phase == PhDbl && w_bit) begin
            w_phase_d = PhAdd;
            w_state_d = SqStep;
         end else if (r_idx == '0) begin
            w_state_d = SqFin;
         end else begin
            w_idx_d   = r_idx - IDX_W'(1);
            w_phase_d = PhDbl;
            w_state_d = SqStep;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= SqIdle;
         r_phase <= PhDbl;
         r_idx   <= '0;
         r_k     <= '0;
         r_p     <= POINT_INF;
         r_r     <= POINT_INF;
         r_done  <= 1'b0;
         r_rx    <= '0;
         r_ry    <= '0;
      end else begin
         r_state <= w_state_d;
         r_phase <= w_phase_d;
         r_idx   <= w_idx_d;
         r_r     <= w_r_d;
         r_done  <= (r_state == SqFin);
         if (r_state == SqIdle && start) begin
            r_k <= k;
            r_p <= {px[COORD_W-1:0], py[COORD_W-1:0]};
         end
         if (r_state == SqFin) begin
            r_rx <= {1'b0, r_r.x};
            r_ry <= {1'b0, r_r.y};
         end
      end
   end

`ifdef ECC_SCALAR_MULT_TIMEOUT_EN
   logic r_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else if (r_state == SqIdle && start) begin
         r_err <= 1'b0;
      end else if (r_state == SqCore && w_timeout) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   ecc_core_req #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_core_req (
      .clk        (clk),
      .reset      (reset),
      .i_go       (w_go),
      .i_px       (w_op_px),
      .i_py       (w_op_py),
      .i_qx       (w_op_qx),
      .i_qy       (w_op_qy),
      .o_capture  (w_capture),
      .o_res      (w_res),
      .o_finish   (w_finish),
      .o_timeout  (w_timeout),
      .core_start (core_start),
      .core_px    (core_px),
      .core_py    (core_py),
      .core_qx    (core_qx),
      .core_qy    (core_qy),
      .core_done  (core_done),
      .core_rx    (core_rx),
      .core_ry    (core_ry)
   );

   assign busy = (r_state != SqIdle);
   assign done = r_done;
   assign rx   = r_rx;
   assign ry   = r_ry;

endmodule

// File: tb/tb_ecc_scalar_mult.sv
module tb_ecc_scalar_mult;

   localparam int unsigned K_W = 79;

   localparam logic [79:0] PX     = 80'h30CB127B63E42792F10F;
   localparam logic [79:0] PY     = 80'h547B2C88266BB04F713B;
   localparam logic [79:0] PX_DBL = 80'hB0CB127B63E42792F10F;

   logic          clk, reset, start;
   logic [K_W-1:0] k;
   logic [79:0]   px, py, rx, ry, core_px, core_py, core_qx, core_qy, core_rx, core_ry;
   logic          busy, done, err, core_start, core_done;

   int checks   = 0;
   int failures = 0;

   // Core model: scripted results, latency 5 cycles, done held 2 cycles.
   logic [79:0] scr_rx [3];
   logic [79:0] scr_ry [3];
   logic [79:0] log_px [$];
   logic [79:0] log_py [$];
   logic [79:0] log_qx [$];
   logic [79:0] log_qy [$];
   int          n_starts = 0;
   bit          core_silent = 0;

   ecc_scalar_mult #(
      .K_W            (K_W),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .k          (k),
      .px         (px),
      .py         (py),
      .busy       (busy),
      .done       (done),
      .rx         (rx),
      .ry         (ry),
      .err        (err),
      .core_start (core_start),
      .core_px    (core_px),
      .core_py    (core_py),
      .core_qx    (core_qx),
      .core_qy    (core_qy),
      .core_done  (core_done),
      .core_rx    (core_rx),
      .core_ry    (core_ry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      scr_rx[0] = 80'h8123456789ABCDEF0123;  scr_ry[0] = 80'h7EDCBA98765432100FED;
      scr_rx[1] = 80'h2222333344445555666A;  scr_ry[1] = 80'hC1111000022223333444;
      scr_rx[2] = 80'h0ABCDEF0123456789ABC;  scr_ry[2] = 80'h00000000000000000001;
   end

   initial begin
      int idx;
      core_done = 1'b0;
      core_rx   = '0;
      core_ry   = '0;
      forever begin
         @(negedge clk);
         if (core_start) begin
            log_px.push_back(core_px);
            log_py.push_back(core_py);
            log_qx.push_back(core_qx);
            log_qy.push_back(core_qy);
            idx = n_starts % 3;
            n_starts++;
            if (!core_silent) begin
               repeat (5) @(posedge clk);
               #1 core_done = 1'b1;
               core_rx = scr_rx[idx];
               core_ry = scr_ry[idx];
               repeat (2) @(posedge clk);
               #1 core_done = 1'b0;
            end
         end
      end
   end

   task automatic clear_log();
      n_starts = 0;
      log_px.delete();
      log_py.delete();
      log_qx.delete();
      log_qy.delete();
   endtask

   // Drives one request and waits (bounded) for done. poke_at>0 re-asserts start
   // with k='1 on that cycle of the run.
   task automatic run_op(input logic [K_W-1:0] kv, input int poke_at, output int cyc,
                         output bit ok, output logic busy_s, output logic done2);
      @(negedge clk);
      k = kv; px = PX; py = PY; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      busy_s = busy;
      cyc = 0;
      ok  = 0;
      while (!ok && cyc < 3000) begin
         @(posedge clk);
         cyc++;
         #1;
         if (cyc == poke_at) begin
            start = 1'b1;
            k = '1;
         end else begin
            start = 1'b0;
         end
         if (done) ok = 1;
      end
      start = 1'b0;
      @(posedge clk);
      #1 done2 = done;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; k = '0; px = '0; py = '0;
      #23 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got %b want 0", err); end
      checks++; if (core_start !== 1'b0) begin failures++; $display("FAIL reset_core_start got %b want 0", core_start); end
      checks++; if ({rx, ry} !== 160'd0) begin failures++; $display("FAIL reset_rxry got %h %h want 0", rx, ry); end
      checks++;
      if ({core_px, core_py, core_qx, core_qy} !== 320'd0) begin
         failures++; $display("FAIL reset_core_ops got %h %h want 0", core_px, core_qx);
      end
   endtask

   task automatic test_k1();
      int cyc; bit ok; logic b, d2;
      clear_log();
      run_op(79'd1, 0, cyc, ok, b, d2);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL k1_done_seen got %b want 1", ok); end
      checks++; if (cyc != K_W + 2) begin failures++; $display("FAIL k1_latency got %0d want %0d", cyc, K_W + 2); end
      checks++; if (b !== 1'b1) begin failures++; $display("FAIL k1_busy got %b want 1", b); end
      checks++; if (d2 !== 1'b0) begin failures++; $display("FAIL k1_done_width got %b want 0", d2); end
      checks++; if (n_starts != 0) begin failures++; $display("FAIL k1_core_starts got %0d want 0", n_starts); end
      checks++; if (rx !== PX) begin failures++; $display("FAIL k1_rx got %h want %h", rx, PX); end
      checks++; if (ry !== PY) begin failures++; $display("FAIL k1_ry got %h want %h", ry, PY); end
   endtask

   task automatic test_k2();
      int cyc; bit ok; logic b, d2;
      clear_log();
      run_op(79'd2, 0, cyc, ok, b, d2);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL k2_done_seen got %b want 1", ok); end
      checks++; if (n_starts != 1) begin failures++; $display("FAIL k2_core_starts got %0d want 1", n_starts); end
      if (log_px.size() >= 1) begin
         checks++; if (log_px[0] !== PX_DBL) begin failures++; $display("FAIL k2_op_px got %h want %h", log_px[0], PX_DBL); end
         checks++; if (log_py[0] !== PY) begin failures++; $display("FAIL k2_op_py got %h want %h", log_py[0], PY); end
         checks++;
         if ({log_qx[0], log_qy[0]} !== 160'd0) begin
            failures++; $display("FAIL k2_op_q got %h %h want 0", log_qx[0], log_qy[0]);
         end
      end
      checks++; if (rx !== 80'h0123456789ABCDEF0123) begin failures++; $display("FAIL k2_rx got %h want 0123456789abcdef0123", rx); end
      checks++; if (ry !== 80'h7EDCBA98765432100FED) begin failures++; $display("FAIL k2_ry got %h want 7edcba98765432100fed", ry); end
   endtask

   // Also pokes start mid-run: it must be ignored.
   task automatic test_k3();
      int cyc; bit ok; logic b, d2;
      clear_log();
      run_op(79'd3, 90, cyc, ok, b, d2);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL k3_done_seen got %b want 1", ok); end
      checks++; if (n_starts != 2) begin failures++; $display("FAIL k3_core_starts got %0d want 2", n_starts); end
      if (log_px.size() >= 2) begin
         checks++; if (log_px[0] !== PX_DBL) begin failures++; $display("FAIL k3_dbl_px got %h want %h", log_px[0], PX_DBL); end
         checks++; if (log_px[1] !== 80'h0123456789ABCDEF0123) begin failures++; $display("FAIL k3_add_px got %h want 0123456789abcdef0123", log_px[1]); end
         checks++; if (log_py[1] !== 80'h7EDCBA98765432100FED) begin failures++; $display("FAIL k3_add_py got %h want 7edcba98765432100fed", log_py[1]); end
         checks++; if (log_qx[1] !== PX) begin failures++; $display("FAIL k3_add_qx got %h want %h", log_qx[1], PX); end
         checks++; if (log_qy[1] !== PY) begin failures++; $display("FAIL k3_add_qy got %h want %h", log_qy[1], PY); end
      end
      checks++; if (rx !== 80'h2222333344445555666A) begin failures++; $display("FAIL k3_rx got %h want 2222333344445555666a", rx); end
      checks++; if (ry !== 80'h41111000022223333444) begin failures++; $display("FAIL k3_ry got %h want 41111000022223333444", ry); end
   endtask

   task automatic test_k0();
      int cyc; bit ok; logic b, d2;
      clear_log();
      run_op(79'd0, 0, cyc, ok, b, d2);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL k0_done_seen got %b want 1", ok); end
      checks++; if (n_starts != 0) begin failures++; $display("FAIL k0_core_starts got %0d want 0", n_starts); end
      checks++; if ({rx, ry} !== 160'd0) begin failures++; $display("FAIL k0_result got %h %h want 0", rx, ry); end
   endtask

   task automatic test_reset_midop();
      int cyc; bit ok; logic b, d2;
      int n;
      clear_log();
      @(negedge clk);
      k = 79'd5; px = PX; py = PY; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      while (!core_start && n < 300) begin @(posedge clk); #1 n++; end
      checks++; if (core_start !== 1'b1) begin failures++; $display("FAIL midop_core_start_seen got %b want 1", core_start); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midop_busy got %b want 0", busy); end
      checks++; if (core_start !== 1'b0) begin failures++; $display("FAIL midop_core_start got %b want 0", core_start); end
      checks++; if (core_px !== 80'd0) begin failures++; $display("FAIL midop_core_px got %h want 0", core_px); end
      repeat (20) @(posedge clk);
      #1 reset = 1'b1;
      clear_log();
      run_op(79'd5, 0, cyc, ok, b, d2);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL k5_done_seen got %b want 1", ok); end
      checks++; if (n_starts != 3) begin failures++; $display("FAIL k5_core_starts got %0d want 3", n_starts); end
      if (log_px.size() >= 3) begin
         checks++; if (log_px[1] !== 80'h8123456789ABCDEF0123) begin failures++; $display("FAIL k5_dbl2_px got %h want 8123456789abcdef0123", log_px[1]); end
         checks++; if (log_qx[1] !== 80'd0) begin failures++; $display("FAIL k5_dbl2_qx got %h want 0", log_qx[1]); end
         checks++; if (log_px[2] !== 80'h2222333344445555666A) begin failures++; $display("FAIL k5_add_px got %h want 2222333344445555666a", log_px[2]); end
         checks++; if (log_py[2] !== 80'h41111000022223333444) begin failures++; $display("FAIL k5_add_py got %h want 41111000022223333444", log_py[2]); end
         checks++; if (log_qx[2] !== PX) begin failures++; $display("FAIL k5_add_qx got %h want %h", log_qx[2], PX); end
      end
      checks++; if (rx !== 80'h0ABCDEF0123456789ABC) begin failures++; $display("FAIL k5_rx got %h want 0abcdef0123456789abc", rx); end
      checks++; if (ry !== 80'h00000000000000000001) begin failures++; $display("FAIL k5_ry got %h want 1", ry); end
   endtask

`ifdef ECC_SCALAR_MULT_TIMEOUT_EN
   task automatic test_timeout();
      int cyc; bit ok; logic b, d2;
      clear_log();
      core_silent = 1;
      run_op(79'd2, 0, cyc, ok, b, d2);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL to_done_seen got %b want 1", ok); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err got %b want 1", err); end
      checks++; if ({rx, ry} !== 160'd0) begin failures++; $display("FAIL to_result got %h %h want 0", rx, ry); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err_sticky got %b want 1", err); end
      core_silent = 0;
      clear_log();
      run_op(79'd1, 0, cyc, ok, b, d2);
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL to_err_clear got %b want 0", err); end
      checks++; if (rx !== PX) begin failures++; $display("FAIL to_next_rx got %h want %h", rx, PX); end
   endtask
`endif

   initial begin
      test_reset();
      test_k1();
      test_k2();
      test_k3();
      test_k0();
      test_reset_midop();
`ifdef ECC_SCALAR_MULT_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
